// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch-stage program counter with compare-branch resolution,
// optional MIPS delay slot, invalid-PC trap, illegal-op pulse and a saturating
// taken-branch counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | normal sequential fetch; a taken branch is resolved here
// PENDING | delay-slot instruction fetched; next edge loads pend_tgt
module branch_pc_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h00400000,
  parameter int              IMEM_WORDS = 1024,
  parameter bit              DELAY_SLOT = 1'b1,
  parameter int              CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_en,
  input  logic [2:0]       br_type,
  input  logic [XLEN-1:0]  rs_val,
  input  logic [XLEN-1:0]  rt_val,
  input  logic [15:0]      imm16,
  output logic [XLEN-1:0]  pc,
  output logic             taken,
  output logic             invpc,
  output logic             iop,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  // Valid range compared one bit wider so RESET_PC + size cannot overflow.
  localparam logic [XLEN:0]    PC_LO   = {1'b0, RESET_PC};
  localparam logic [XLEN:0]    PC_HI   = PC_LO + (XLEN+1)'(4 * IMEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic             invpc_q, invpc_d;
  logic             iop_q, iop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cond;
  logic             illegal;
  logic             accept;
  logic             taken_w;
  logic             rs_neg;
  logic             rs_zero;
  logic [XLEN-1:0]  br_off;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  target;
  logic             pc_d_ok;

  // State register: all architectural state, synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      invpc_q <= 1'b0;
      iop_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      invpc_q <= invpc_d;
      iop_q   <= iop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Branch decode: signed compare, acceptance and target address.
  always_comb begin
    rs_neg   = rs_val[XLEN-1];
    rs_zero  = (rs_val == '0);
    illegal  = br_type[2] & br_type[1];
    cond     = 1'b0;
    case (br_type)
      3'd0:    cond = (rs_val == rt_val);
      3'd1:    cond = (rs_val != rt_val);
      3'd2:    cond = rs_neg | rs_zero;
      3'd3:    cond = ~rs_neg & ~rs_zero;
      3'd4:    cond = rs_neg;
      3'd5:    cond = ~rs_neg;
      default: cond = 1'b0;
    endcase
    // A branch sitting in the delay slot is not a branch at all.
    accept   = br_en & ~stall & ~invpc_q & ~(DELAY_SLOT && (state_q == PENDING));
    taken_w  = accept & cond;
    br_off   = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
    pc_plus4 = pc_q + XLEN'(4);
    target   = pc_plus4 + br_off;
  end

  // Next-state: PC sequencing, range trap and counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    invpc_d = invpc_q;
    cnt_d   = cnt_q;
    iop_d   = accept & illegal;
    pc_d_ok = 1'b1;
    if (!stall && !invpc_q) begin
      case (state_q)
        PENDING: begin
          pc_d    = tgt_q;
          state_d = IDLE;
        end
        default: begin
          if (taken_w && DELAY_SLOT) begin
            pc_d    = pc_plus4;
            tgt_d   = target;
            state_d = PENDING;
          end else if (taken_w) begin
            pc_d = target;
          end else begin
            pc_d = pc_plus4;
          end
        end
      endcase
      // The out-of-range value is still loaded; invpc then freezes it.
      pc_d_ok = ({1'b0, pc_d} >= PC_LO) && ({1'b0, pc_d} < PC_HI);
      invpc_d = ~pc_d_ok;
      if (taken_w && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs: registered state plus the same-cycle taken decision.
  always_comb begin
    pc        = pc_q;
    taken     = taken_w;
    invpc     = invpc_q;
    iop       = iop_q;
    taken_cnt = cnt_q;
  end

endmodule
